// File: rtl/net_packet_rx_pkg.sv
// Shared types for the core-side network packet receiver: packet layout,
// opcodes, instruction word shape and receiver states.
package net_packet_rx_pkg;

   localparam int mask_length_gp    = 8;
   localparam int rd_size_gp        = 5;
   localparam int rs_imm_size_gp    = 5;
   localparam int net_id_width_gp   = 10;
   localparam int net_addr_width_gp = 16;
   localparam int net_data_width_gp = 32;

   typedef enum logic [2:0] {
      NET_NULL  = 3'd0,
      NET_INSTR = 3'd1,
      NET_REG   = 3'd2,
      NET_PC    = 3'd3,
      NET_BAR   = 3'd4
   } net_op_e;

   typedef struct packed {
      logic [5:0]                opcode;
      logic [rd_size_gp-1:0]     rd;
      logic [rs_imm_size_gp-1:0] rs_imm;
   } instruction_s;

   typedef struct packed {
      logic [net_id_width_gp-1:0]   net_id;
      net_op_e                      net_op;
      logic [net_addr_width_gp-1:0] net_addr;
      logic [net_data_width_gp-1:0] net_data;
   } net_packet_s;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } rx_state_e;

   // Encodings 5..7 are reserved and flagged as protocol errors.
   function automatic logic net_op_defined(input net_op_e op);
      return op inside {NET_NULL, NET_INSTR, NET_REG, NET_PC, NET_BAR};
   endfunction

endpackage

// File: rtl/net_packet_rx_reg_write_fifo.sv
// Small synchronous FIFO buffering register writes while the core owns the
// register-file write port; a push into a full FIFO lands only alongside a pop.
module reg_write_fifo #(
   parameter int width_p = 37,
   parameter int depth_p = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  logic [width_p-1:0] i_data,
   input  logic               i_pop,
   output logic [width_p-1:0] o_head,
   output logic               o_full,
   output logic               o_empty
);
   localparam int ptr_width_lp = $clog2(depth_p);
   localparam logic [ptr_width_lp:0] ptr_one_lp = 1;

   logic [width_p-1:0]    r_mem [depth_p];
   logic [ptr_width_lp:0] r_wptr;
   logic [ptr_width_lp:0] r_rptr;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[ptr_width_lp] != r_rptr[ptr_width_lp]) &&
                      (r_wptr[ptr_width_lp-1:0] == r_rptr[ptr_width_lp-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rptr[ptr_width_lp-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + ptr_one_lp;
         if (w_do_pop)  r_rptr <= r_rptr + ptr_one_lp;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[ptr_width_lp-1:0]] <= i_data;
   end

endmodule

// File: rtl/net_packet_rx.sv
// Core-side network packet receiver: filters by core ID and turns packets into
// instruction-memory, register-file, barrier and PC/run updates for the core.
module net_packet_rx
   import net_packet_rx_pkg::*;
#(
   parameter logic [net_id_width_gp-1:0] core_id_p = 10'd1,
   parameter int imem_addr_width_p = 10,
   parameter int rf_addr_width_p   = rs_imm_size_gp,
   parameter int reg_fifo_depth_p  = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [$bits(net_packet_s)-1:0]    net_packet_flat_i,
   input  logic                              rf_busy_i,
   input  logic                              halt_i,
   output logic                              imem_wen_o,
   output logic [imem_addr_width_p-1:0]      imem_addr_o,
   output logic [$bits(instruction_s)-1:0]   imem_wdata_o,
   output logic                              rf_wen_o,
   output logic [rf_addr_width_p-1:0]        rf_waddr_o,
   output logic [31:0]                       rf_wdata_o,
   output logic                              pc_wen_o,
   output logic [imem_addr_width_p-1:0]      pc_wdata_o,
   output logic [mask_length_gp-1:0]         barrier_mask_o,
   output logic                              run_o,
   output logic                              drop_o,
   output logic                              protocol_err_o
);
   localparam int entry_width_lp = rf_addr_width_p + 32;

   net_packet_s               w_pkt;
   rx_state_e                 r_state;
   rx_state_e                 w_state_next;
   logic                      w_accept;
   logic                      w_is_instr;
   logic                      w_is_reg;
   logic                      w_is_pc;
   logic                      w_is_bar;
   logic                      w_bad_op;
   logic                      w_load;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_drop;
   logic                      w_err;
   logic                      w_full;
   logic                      w_empty;
   logic [entry_width_lp-1:0] w_head;
   logic                      w_imem_wen;
   logic                      w_pc_wen;
   logic                      w_unused;

   assign w_pkt      = net_packet_s'(net_packet_flat_i);
   assign w_accept   = (w_pkt.net_id == core_id_p);
   assign w_is_instr = w_accept && (w_pkt.net_op == NET_INSTR);
   assign w_is_reg   = w_accept && (w_pkt.net_op == NET_REG);
   assign w_is_pc    = w_accept && (w_pkt.net_op == NET_PC);
   assign w_is_bar   = w_accept && (w_pkt.net_op == NET_BAR);
   assign w_bad_op   = w_accept && !net_op_defined(w_pkt.net_op);
   assign w_load     = (r_state == LOAD);
   assign w_push     = w_is_reg && w_load;
   assign w_pop      = !w_empty && !rf_busy_i;
   assign w_drop     = w_push && w_full && !w_pop;
   assign w_err      = w_bad_op || ((w_is_instr || w_is_reg) && !w_load);
   assign w_unused   = ^w_pkt.net_addr[net_addr_width_gp-1:imem_addr_width_p];

   reg_write_fifo #(
      .width_p (entry_width_lp),
      .depth_p (reg_fifo_depth_p)
   ) u_reg_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  ({w_pkt.net_addr[rf_addr_width_p-1:0], w_pkt.net_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign rf_wen_o   = w_pop;
   assign rf_waddr_o = w_pop ? w_head[entry_width_lp-1:32] : '0;
   assign rf_wdata_o = w_pop ? w_head[31:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= LOAD;
      else        r_state <= w_state_next;
   end

   // DRAIN leaves only on an edge where the FIFO is already seen empty, so the
   // PC load lands the cycle after the last buffered register write retires.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         LOAD:    if (w_is_pc) w_state_next = w_empty ? RUN : DRAIN;
         DRAIN:   if (w_empty) w_state_next = RUN;
         RUN:     if (halt_i)  w_state_next = LOAD;
         default: w_state_next = LOAD;
      endcase
   end

   always_comb begin
      w_imem_wen = w_is_instr && w_load;
      w_pc_wen   = 1'b0;
      unique case (r_state)
         LOAD:    w_pc_wen = w_is_pc && w_empty;
         DRAIN:   w_pc_wen = w_empty;
         RUN:     w_pc_wen = w_is_pc;
         default: w_pc_wen = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         imem_wen_o     <= 1'b0;
         imem_addr_o    <= '0;
         imem_wdata_o   <= '0;
         pc_wen_o       <= 1'b0;
         pc_wdata_o     <= '0;
         barrier_mask_o <= '0;
         run_o          <= 1'b0;
         drop_o         <= 1'b0;
         protocol_err_o <= 1'b0;
      end else begin
         imem_wen_o <= w_imem_wen;
         if (w_imem_wen) begin
            imem_addr_o  <= w_pkt.net_addr[imem_addr_width_p-1:0];
            imem_wdata_o <= w_pkt.net_data[$bits(instruction_s)-1:0];
         end
         pc_wen_o <= w_pc_wen;
         if (w_is_pc)  pc_wdata_o     <= w_pkt.net_addr[imem_addr_width_p-1:0];
         if (w_is_bar) barrier_mask_o <= w_pkt.net_data[mask_length_gp-1:0];
         run_o <= (w_state_next == RUN);
         if (w_drop) drop_o         <= 1'b1;
         if (w_err)  protocol_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_net_packet_rx.sv
// Self-checking bench for net_packet_rx: directed scenarios pinned with literal
// expectations, then randomized packets compared against a behavioural model.
module tb_net_packet_rx;
   import net_packet_rx_pkg::*;

   localparam logic [9:0] CORE_ID = 10'd1;
   localparam int DEPTH = 4;
   localparam int PKTW  = $bits(net_packet_s);
   localparam logic [2:0] OP_NULL = 3'd0, OP_INSTR = 3'd1, OP_REG = 3'd2,
                          OP_PC = 3'd3, OP_BAR = 3'd4;
   localparam int MODE_LOAD = 0, MODE_DRAIN = 1, MODE_RUN = 2;

   logic            clk;
   logic            reset;
   logic [PKTW-1:0] pktFlat;
   logic            rfBusy;
   logic            haltIn;
   logic            imem_wen_o;
   logic [9:0]      imem_addr_o;
   logic [15:0]     imem_wdata_o;
   logic            rf_wen_o;
   logic [4:0]      rf_waddr_o;
   logic [31:0]     rf_wdata_o;
   logic            pc_wen_o;
   logic [9:0]      pc_wdata_o;
   logic [7:0]      barrier_mask_o;
   logic            run_o;
   logic            drop_o;
   logic            protocol_err_o;

   int assertCount = 0;
   int failCount   = 0;

   // Behavioural model state: buffered register writes and expected outputs.
   logic [36:0] regQ[$];
   int          modeV;
   logic        expImemWen, expPcWen, expRun, expDrop, expErr;
   logic [9:0]  expImemAddr, expPcVal;
   logic [15:0] expImemData;
   logic [7:0]  expMask;

   net_packet_rx dut (
      .clk               (clk),
      .reset             (reset),
      .net_packet_flat_i (pktFlat),
      .rf_busy_i         (rfBusy),
      .halt_i            (haltIn),
      .imem_wen_o        (imem_wen_o),
      .imem_addr_o       (imem_addr_o),
      .imem_wdata_o      (imem_wdata_o),
      .rf_wen_o          (rf_wen_o),
      .rf_waddr_o        (rf_waddr_o),
      .rf_wdata_o        (rf_wdata_o),
      .pc_wen_o          (pc_wen_o),
      .pc_wdata_o        (pc_wdata_o),
      .barrier_mask_o    (barrier_mask_o),
      .run_o             (run_o),
      .drop_o            (drop_o),
      .protocol_err_o    (protocol_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      regQ.delete();
      modeV       = MODE_LOAD;
      expImemWen  = 1'b0;
      expPcWen    = 1'b0;
      expRun      = 1'b0;
      expDrop     = 1'b0;
      expErr      = 1'b0;
      expImemAddr = '0;
      expPcVal    = '0;
      expImemData = '0;
      expMask     = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelStep();
      net_packet_s p;
      logic        acc;
      logic        wasEmpty;
      int          oldMode;
      logic [2:0]  op;
      p        = net_packet_s'(pktFlat);
      op       = p.net_op;
      acc      = (p.net_id == CORE_ID);
      wasEmpty = (regQ.size() == 0);
      oldMode  = modeV;
      if (!wasEmpty && !rfBusy) void'(regQ.pop_front());
      expImemWen = 1'b0;
      expPcWen   = 1'b0;
      if (acc) begin
         case (op)
            OP_NULL: ;
            OP_INSTR:
               if (oldMode == MODE_LOAD) begin
                  expImemWen  = 1'b1;
                  expImemAddr = p.net_addr[9:0];
                  expImemData = p.net_data[15:0];
               end else expErr = 1'b1;
            OP_REG:
               if (oldMode == MODE_LOAD) begin
                  if (regQ.size() < DEPTH) regQ.push_back({p.net_addr[4:0], p.net_data});
                  else expDrop = 1'b1;
               end else expErr = 1'b1;
            OP_PC: begin
               expPcVal = p.net_addr[9:0];
               if (oldMode == MODE_LOAD) begin
                  if (wasEmpty) begin
                     expPcWen = 1'b1;
                     modeV    = MODE_RUN;
                  end else modeV = MODE_DRAIN;
               end else if (oldMode == MODE_RUN) expPcWen = 1'b1;
            end
            OP_BAR: expMask = p.net_data[7:0];
            default: expErr = 1'b1;
         endcase
      end
      if (oldMode == MODE_DRAIN && wasEmpty) begin
         expPcWen = 1'b1;
         modeV    = MODE_RUN;
      end
      if (oldMode == MODE_RUN && haltIn) modeV = MODE_LOAD;
      expRun = (modeV == MODE_RUN);
   endtask

   // Single compare process: every negedge, all outputs against the model.
   always @(negedge clk) begin
      logic expRfWen;
      expRfWen = reset && (regQ.size() > 0) && !rfBusy;
      checkOutput("imemWen", imem_wen_o, expImemWen);
      if (expImemWen) begin
         checkOutput("imemAddr", imem_addr_o, expImemAddr);
         checkOutput("imemData", imem_wdata_o, expImemData);
      end
      checkOutput("rfWen", rf_wen_o, expRfWen);
      if (expRfWen) checkOutput("rfHead", {rf_waddr_o, rf_wdata_o}, regQ[0]);
      checkOutput("pcWen", pc_wen_o, expPcWen);
      checkOutput("pcData", pc_wdata_o, expPcVal);
      checkOutput("mask", barrier_mask_o, expMask);
      checkOutput("run", run_o, expRun);
      checkOutput("drop", drop_o, expDrop);
      checkOutput("protoErr", protocol_err_o, expErr);
   end

   task automatic applyStimulus(input logic [9:0] id, input logic [2:0] op, input logic [15:0] addr,
                                input logic [31:0] data, input logic busy, input logic halt);
      @(posedge clk);
      if (reset) modelStep();
      else modelReset();
      #1;
      pktFlat = {id, op, addr, data};
      rfBusy  = busy;
      haltIn  = halt;
   endtask

   task automatic idle(input logic busy);
      applyStimulus(CORE_ID, OP_NULL, 16'd0, 32'd0, busy, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "A"}, {imem_wen_o, imem_addr_o, imem_wdata_o, rf_wen_o, pc_wen_o,
                               run_o, drop_o, protocol_err_o}, '0);
      checkOutput({tag, "B"}, {pc_wdata_o, barrier_mask_o, rf_waddr_o, rf_wdata_o}, '0);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #2;
      reset   = 1'b0;
      pktFlat = '0;
      rfBusy  = 1'b0;
      haltIn  = 1'b0;
      modelReset();
      #1;
      checkAllZero("asyncReset");
      @(negedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b1;
      pktFlat = '0;
      rfBusy  = 1'b0;
      haltIn  = 1'b0;
      modelReset();
      #1 reset = 1'b0;
      #1 checkAllZero("powerOnReset");
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;

      // INSTR for this core, then the same packet for another core.
      applyStimulus(CORE_ID, OP_INSTR, 16'd3, 32'h0000A5C3, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("instrWen", imem_wen_o, 1'b1);
      checkOutput("instrAddr", imem_addr_o, 10'd3);
      checkOutput("instrData", imem_wdata_o, 16'hA5C3);
      applyStimulus(10'd2, OP_INSTR, 16'd3, 32'h0000A5C3, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("otherIdWen", imem_wen_o, 1'b0);
      checkOutput("otherIdErr", protocol_err_o, 1'b0);

      applyStimulus(CORE_ID, OP_BAR, 16'd0, 32'h2, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("barLoad", barrier_mask_o, 8'h02);

      // Five REGs while busy: four buffered, the fifth dropped.
      for (int i = 1; i <= 5; i++)
         applyStimulus(CORE_ID, OP_REG, 16'(i), 32'(i * 32'h11), 1'b1, 1'b0);
      idle(1'b1);
      @(negedge clk);
      checkOutput("busyHold", rf_wen_o, 1'b0);
      checkOutput("dropSet", drop_o, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         idle(1'b0);
         @(negedge clk);
         checkOutput("drainWen", rf_wen_o, 1'b1);
         checkOutput("drainAddr", rf_waddr_o, 5'(i));
         checkOutput("drainData", rf_wdata_o, 32'(i * 32'h11));
      end

      // PC with buffered REGs goes through DRAIN before running.
      applyStimulus(CORE_ID, OP_REG, 16'd6, 32'h66, 1'b1, 1'b0);
      applyStimulus(CORE_ID, OP_REG, 16'd7, 32'h77, 1'b1, 1'b0);
      applyStimulus(CORE_ID, OP_PC, 16'd0, 32'd0, 1'b1, 1'b0);
      repeat (3) idle(1'b0);
      @(negedge clk);
      checkOutput("drainNoPc", pc_wen_o, 1'b0);
      checkOutput("drainNoRun", run_o, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("drainPcWen", pc_wen_o, 1'b1);
      checkOutput("drainPcVal", pc_wdata_o, 10'd0);
      checkOutput("drainRun", run_o, 1'b1);

      applyStimulus(CORE_ID, OP_BAR, 16'd0, 32'h3, 1'b0, 1'b0);
      applyStimulus(CORE_ID, OP_BAR, 16'd0, 32'h2, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("barRun", barrier_mask_o, 8'h02);

      applyStimulus(CORE_ID, OP_INSTR, 16'd5, 32'h1111, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("runInstrWen", imem_wen_o, 1'b0);
      checkOutput("runInstrErr", protocol_err_o, 1'b1);
      applyStimulus(CORE_ID, OP_NULL, 16'd0, 32'd0, 1'b0, 1'b1);
      idle(1'b0);
      @(negedge clk);
      checkOutput("haltRun", run_o, 1'b0);
      applyStimulus(CORE_ID, OP_INSTR, 16'd6, 32'h1234, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("reloadWen", imem_wen_o, 1'b1);
      checkOutput("reloadAddr", imem_addr_o, 10'd6);

      // Reset in DRAIN with three REGs buffered discards them.
      for (int i = 8; i <= 10; i++)
         applyStimulus(CORE_ID, OP_REG, 16'(i), 32'(i), 1'b1, 1'b0);
      applyStimulus(CORE_ID, OP_PC, 16'd9, 32'd0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      resetDut();
      idle(1'b0);
      idle(1'b0);
      @(negedge clk);
      checkOutput("postResetRfWen", rf_wen_o, 1'b0);
      checkOutput("postResetRun", run_o, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 249) resetDut();
         else begin
            logic [2:0] op;
            int         r;
            r = $urandom_range(0, 31);
            if (r < 4)       op = OP_NULL;
            else if (r < 12) op = OP_INSTR;
            else if (r < 22) op = OP_REG;
            else if (r < 26) op = OP_PC;
            else if (r < 30) op = OP_BAR;
            else if (r < 31) op = 3'($urandom_range(5, 7));
            else             op = OP_NULL;
            applyStimulus(($urandom_range(0, 7) == 0) ? 10'd2 : CORE_ID, op,
                          16'($urandom), $urandom, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 15) == 0));
         end
      end
      idle(1'b0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
